// File: rtl/limd_pkg.sv
// -----------------------------------------------------------------------------
// limd_pkg
// Shared definitions for the multi-channel a1 limiter (limd_mc) and its
// combinational clamp core (limd_core).
//   clamp_e    : clamp event codes reported alongside each limited a1
//   LIMD_WD    : default datapath width
//   LIMD_OMEGA : default limit constant (0.9375 in Q14)
//   limd_ome() : saturated OME = omega - a2p, clipped to [0, 2^(wd-1)-1]
// -----------------------------------------------------------------------------
package limd_pkg;

  typedef enum logic [1:0] {
    CLAMP_NONE = 2'b00,
    CLAMP_HI   = 2'b01,
    CLAMP_LO   = 2'b10
  } clamp_e;

  localparam int LIMD_WD    = 16;
  localparam int LIMD_OMEGA = 15360;

  // a2p arrives sign-extended to 32 bits so one function serves any WD < 32.
  // The difference is formed wider than WD+1 bits; for a WD-bit a2p and an
  // omega below 2^(wd-1) the result is identical to a WD+1-bit subtraction.
  function automatic logic [31:0] limd_ome(input logic signed [31:0] a2p,
                                           input int                 wd,
                                           input int                 omega);
    logic signed [33:0] diff;
    logic signed [33:0] max_v;
    diff  = 34'(omega) - 34'(a2p);
    max_v = (34'sd1 <<< (wd - 1)) - 34'sd1;
    if (diff < 34'sd0) begin
      return '0;
    end
    if (diff > max_v) begin
      return max_v[31:0];
    end
    return diff[31:0];
  endfunction

endpackage

// File: rtl/limd_core.sv
// -----------------------------------------------------------------------------
// limd_core
// Combinational a1 clamp shared by the multi-channel pipeline and the
// single-channel wrapper. Limits a1t to [-ome, +ome] using signed compares.
//   a1t     in  WD  unlimited a1 (two's complement)
//   ome     in  WD  saturated OMEGA - a2p, always in [0, 2^(WD-1)-1]
//   bypass  in  1   pass a1t through untouched, report no clamp
//   a1p     out WD  limited a1
//   clamped out 2   CLAMP_NONE / CLAMP_HI / CLAMP_LO
// -----------------------------------------------------------------------------
module limd_core
  import limd_pkg::*;
#(
  parameter int WD = LIMD_WD
) (
  input  logic [WD-1:0] a1t,
  input  logic [WD-1:0] ome,
  input  logic          bypass,
  output logic [WD-1:0] a1p,
  output clamp_e        clamped
);

  // ome never exceeds 2^(WD-1)-1, so its negation is always representable.
  logic [WD-1:0] lower_lim;
  assign lower_lim = -ome;

  always_comb begin
    a1p     = a1t;
    clamped = CLAMP_NONE;
    if (!bypass) begin
      if ($signed(a1t) > $signed(ome)) begin
        a1p     = ome;
        clamped = CLAMP_HI;
      end else if ($signed(a1t) < $signed(lower_lim)) begin
        a1p     = lower_lim;
        clamped = CLAMP_LO;
      end
    end
  end

endmodule

// File: rtl/limd_mc.sv
// -----------------------------------------------------------------------------
// limd_mc
// Multi-channel, two-stage pipelined a1 limiter with per-channel saturating
// clamp-event counters.
//   clk, reset             clock (rising) / asynchronous active-low reset
//   in_valid/in_ready      input handshake; in_ch, a1t, a2p, bypass per beat
//   out_valid/out_ready    output handshake; out_ch, a1p, clamped per result
//   stat_ch, stat_clr      counter read select / clear strobe
//   stat_cnt               registered counter value for stat_ch
//   scan_*, test_mode      DFT hooks, inert in RTL (scan_out* tied low)
// Stage 1 holds the beat plus its saturated OME; stage 2 holds the clamped
// result. Each stage only loads when the stage after it can move, so two
// beats can be parked under backpressure without loss or reordering.
// -----------------------------------------------------------------------------
module limd_mc
  import limd_pkg::*;
#(
  parameter  int NCH   = 32,
  parameter  int WD    = LIMD_WD,
  parameter  int OMEGA = LIMD_OMEGA,
  parameter  int CNTW  = 8,
  localparam int CHW   = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CHW-1:0]  in_ch,
  input  logic [WD-1:0]   a1t,
  input  logic [WD-1:0]   a2p,
  input  logic            bypass,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CHW-1:0]  out_ch,
  output logic [WD-1:0]   a1p,
  output logic [1:0]      clamped,
  input  logic [CHW-1:0]  stat_ch,
  input  logic            stat_clr,
  output logic [CNTW-1:0] stat_cnt,
  input  logic            scan_in0,
  input  logic            scan_in1,
  input  logic            scan_in2,
  input  logic            scan_in3,
  input  logic            scan_in4,
  input  logic            scan_enable,
  input  logic            test_mode,
  output logic            scan_out0,
  output logic            scan_out1,
  output logic            scan_out2,
  output logic            scan_out3,
  output logic            scan_out4
);

  // ---------------------------------------------------------------- handshake
  logic advance;
  logic in_fire;
  logic out_fire;

  logic            s1_valid_reg;
  logic [CHW-1:0]  s1_ch_reg;
  logic [WD-1:0]   s1_a1t_reg;
  logic [WD-1:0]   s1_ome_reg;
  logic            s1_bypass_reg;

  logic            s2_valid_reg;
  logic [CHW-1:0]  out_ch_reg;
  logic [WD-1:0]   a1p_reg;
  clamp_e          clamped_reg;

  // in_ready depends on out_ready and pipeline state only, never on in_valid.
  assign advance  = !s2_valid_reg || out_ready;
  assign in_ready = !s1_valid_reg || advance;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_reg && out_ready;

  // ------------------------------------------------------------------ stage 1
  logic [31:0] ome_wide;
  assign ome_wide = limd_ome(32'($signed(a2p)), WD, OMEGA);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_reg  <= 1'b0;
      s1_ch_reg     <= '0;
      s1_a1t_reg    <= '0;
      s1_ome_reg    <= '0;
      s1_bypass_reg <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_reg <= in_valid;
      end
      if (in_fire) begin
        s1_ch_reg     <= in_ch;
        s1_a1t_reg    <= a1t;
        s1_ome_reg    <= ome_wide[WD-1:0];
        s1_bypass_reg <= bypass;
      end
    end
  end

  // ------------------------------------------------------------------ stage 2
  logic [WD-1:0] core_a1p;
  clamp_e        core_clamped;

  limd_core #(
    .WD (WD)
  ) u_core (
    .a1t     (s1_a1t_reg),
    .ome     (s1_ome_reg),
    .bypass  (s1_bypass_reg),
    .a1p     (core_a1p),
    .clamped (core_clamped)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_reg <= 1'b0;
      out_ch_reg   <= '0;
      a1p_reg      <= '0;
      clamped_reg  <= CLAMP_NONE;
    end else if (advance) begin
      s2_valid_reg <= s1_valid_reg;
      // Data only moves with a real beat, so a bubble leaves the last result
      // visible rather than exposing stage-1 leftovers.
      if (s1_valid_reg) begin
        out_ch_reg  <= s1_ch_reg;
        a1p_reg     <= core_a1p;
        clamped_reg <= core_clamped;
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_ch    = out_ch_reg;
  assign a1p       = a1p_reg;
  assign clamped   = clamped_reg;

  // ---------------------------------------------------------- clamp counters
  logic [NCH*CNTW-1:0] cnt_all;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_cnt
      logic [CNTW-1:0] cnt_reg;
      logic [CNTW-1:0] cnt_next;
      logic            inc;
      logic            clr;

      always_comb begin
        inc      = out_fire && (clamped_reg != CLAMP_NONE) && (out_ch_reg == CHW'(gi));
        clr      = stat_clr && (stat_ch == CHW'(gi));
        cnt_next = cnt_reg;
        if (clr) begin
          // A clear colliding with an event keeps that event.
          cnt_next = inc ? CNTW'(1) : '0;
        end else if (inc && (cnt_reg != '1)) begin
          cnt_next = cnt_reg + CNTW'(1);
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign cnt_all[gi*CNTW +: CNTW] = cnt_reg;
    end
  endgenerate

  // Reads the pre-update value: the register samples the array at the same
  // edge that applies increments and clears.
  logic [CNTW-1:0] stat_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_cnt_reg <= '0;
    end else begin
      stat_cnt_reg <= cnt_all[int'(stat_ch)*CNTW +: CNTW];
    end
  end

  assign stat_cnt = stat_cnt_reg;

  // ---------------------------------------------------------------------- DFT
  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                       scan_enable, test_mode, ome_wide[31:WD]};

endmodule

// File: doc/limd_mc.md
# limd_mc

Multi-channel, pipelined successor to the single-channel LIMD (a1 predictor-coefficient limiter) in the ADPCM datapath. It accepts time-multiplexed per-channel A1T/A2P pairs over a valid/ready handshake and clamps A1T to ±(OMEGA − A2P) in a two-stage pipeline. It keeps a per-channel saturating count of clamp events and sits between the UPA1 stage and the A1 state store in the multi-channel ADPCM core.

## Interface
- NCH, 32, number of channels; CHW = $clog2(NCH)
- WD, 16, two's-complement width of a1t/a2p/a1p
- OMEGA, 15360, limit constant (0.9375 in Q14)
- CNTW, 8, clamp-counter width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat this cycle
- in_ch  in  CHW  channel tag
- a1t  in  WD  unlimited a1 (two's complement)
- a2p  in  WD  limited a2 (two's complement)
- bypass  in  1  pass a1t unchanged, no counting
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_ch  out  CHW  channel tag of result
- a1p  out  WD  limited a1
- clamped  out  2  00 none, 01 upper limit hit, 10 lower limit hit
- stat_ch  in  CHW  counter read/clear select
- stat_clr  in  1  clear counter at stat_ch
- stat_cnt  out  CNTW  counter value for stat_ch, registered
- scan_in0..4, scan_enable, test_mode  in  1 each  DFT; unused in RTL
- scan_out0..4  out  1 each  DFT; tied 0 in RTL

## Operation
- OME = OMEGA − a2p, computed in WD+1 bits.
- Saturate OME to [0, 2^(WD−1)−1]. For |a2p| ≤ 12288 this matches single-channel LIMD bit-exactly.
- Upper limit UL = OME; lower limit LL = −OME.
- a1t > UL → a1p = UL, clamped = 01.
- a1t < LL → a1p = LL, clamped = 10.
- Otherwise a1p = a1t, clamped = 00.
- Comparisons are signed.
- bypass = 1 → a1p = a1t, clamped = 00.
- Counters: NCH × CNTW array, saturating at 2^CNTW−1. Incremented for out_ch when out_valid & out_ready & clamped ≠ 00.
- stat_clr with increment to the same channel in the same cycle → counter = 1, so no event is lost.
- stat_cnt = counter[stat_ch] sampled at the clock edge, before that edge's update.

## Timing
- Stage 1 registers the inputs and OME. Stage 2 registers a1p, clamped and out_ch.
- Latency: 2 cycles from in_valid & in_ready to out_valid.
- Throughput: 1 beat/cycle while out_ready = 1.
- advance = !s2_valid | out_ready.
- in_ready = !s1_valid | advance. in_ready is combinational from out_ready; no combinational path from in_valid.
- out_valid and its data stay stable while out_ready = 0. Beats are never dropped or reordered.
- Up to 2 beats are held under backpressure, then in_ready = 0.
- Reset asserted, including mid-stream: s1_valid and s2_valid = 0; a1p, out_ch, clamped = 0; all counters and stat_cnt = 0; in-flight beats are discarded.
- in_ready = 1 from the first edge after reset deasserts.

## Structure
- Package limd_pkg holds:
  - clamp codes CLAMP_NONE = 2'b00, CLAMP_HI = 2'b01, CLAMP_LO = 2'b10;
  - default OMEGA;
  - the function limd_ome(a2p) implementing saturated OME.
- Sub-module limd_core: combinational clamp (a1t, ome, bypass → a1p, clamped), reused by the single-channel wrapper.
- Counter array in flops (NCH × CNTW = 256 bits); no RAM macro.

## Test plan
- a1t = 20000, a2p = 0, ch 3 → 2 cycles later: a1p = 15360, clamped = 01, out_ch = 3.
- a1t = −8000, a2p = 12288 → a1p = −3072 (0xF400), clamped = 10. a1t = −20000, a2p = −12288 → a1p = −20000, clamped = 00.
- Backpressure: push 4 beats with out_ready = 0 → in_ready drops after 2 accepted. Raise out_ready → all 4 emerge in order, one per cycle.
- 300 clamps on ch 5, CNTW = 8 → stat_cnt = 255. Clamps with bypass = 1 → count unchanged.
- stat_clr on ch 5 in the same cycle as a clamped handshake on ch 5 → next read gives 1.
- reset low for 1 cycle with 2 beats in flight → out_valid = 0, all counters read 0, no stale beat emerges afterwards.
